sdram_fill_resp: RTL and testbench
==================================

// Module: sdram_fill_resp
// PURPOSE
// - Responder end of the dmem_ctrl <-> SDRAM controller block-fill handshake in the Memory stage.
// - Accepts a fill request (start_addr, length) from dmem_ctrl and returns a granted pulse.
// - Splits the fill into SDRAM-row-bounded read bursts and issues them on the SDRAM read port.
// - Writes each returned byte into data memory through the sd_* side of the dmem input mux.
// - Holds busy so that dmem_ctrl keeps d_sb=0 and stalls the pipeline until the fill completes.
// PARAMETERS
// - ROW_LEN   default 512    bytes per SDRAM row (power of 2); driven on row_length
// - DM_DEPTH  default 65536  data-memory bytes; largest legal length
// PORTS
// - ref_clk      in   1   clock
// - rst          in   1   asynchronous, active-high reset
// - request      in   1   fill request from dmem_ctrl, level
// - start_addr   in   25  SDRAM byte address of the first byte
// - length       in   25  byte count of the fill
// - granted      out  1   one-cycle pulse: request accepted
// - busy         out  1   fill in progress
// - row_length   out  16  constant ROW_LEN
// - sd_data      out  8   byte to be written to DM
// - sd_addr      out  16  DM byte address
// - sd_R_nW      out  1   0 = DM write strobe (one cycle), 1 = idle/read
// - err          out  1   sticky: length > DM_DEPTH was truncated; cleared on next grant
// - rd_req       out  1   SDRAM burst request, held until rd_ack
// - rd_addr      out  25  burst start address
// - rd_len       out  16  burst byte count, range 1..ROW_LEN
// - rd_ack       in   1   SDRAM accepted the burst
// - rd_valid     in   1   returned byte valid, one byte per cycle
// - rd_data      in   8   returned byte
// BEHAVIOUR
// - Reset values: granted=0, busy=0, sd_R_nW=1, sd_data=0, sd_addr=0, rd_req=0, rd_addr=0, rd_len=0, err=0; FSM goes to IDLE.
// - States: IDLE, GRANT, ISSUE, STREAM, DONE.
// - IDLE: request=1 latches start_addr and the remaining count rem=min(length,DM_DEPTH).
//   - Sets err when length>DM_DEPTH.
//   - Moves to GRANT; request is not sampled in any other state.
// - GRANT, one cycle: granted=1, busy=1, DM pointer=0; goes to DONE if rem==0, otherwise to ISSUE.
// - busy stays 1 from GRANT through DONE inclusive.
// - ISSUE: burst length blen=min(rem, ROW_LEN - (addr mod ROW_LEN)).
//   - rd_req=1, rd_addr=addr and rd_len=blen are held stable until rd_ack.
//   - rd_ack in the same cycle as rd_req completes the handshake; rd_req drops the next cycle. Then go to STREAM.
// - STREAM: each rd_valid beat registers one DM write on the next cycle.
//   - sd_R_nW=0, sd_data=rd_data, sd_addr=pointer.
//   - Then pointer++ (16-bit wrap), addr++, rem--.
//   - At the last beat of a burst, go to ISSUE if rem!=0, otherwise to DONE.
// - rd_valid outside STREAM is ignored; no DM write happens.
// - DONE, one cycle: waits for the final DM write strobe, then busy=0 and return to IDLE.
//   - A request still high in IDLE starts a new fill (back-to-back allowed).
// - Latency: granted 1 cycle after request; DM write 1 cycle after rd_valid.
// - Widths: rem is 25 bits; blen is computed in 17 bits before truncation to 16 (ROW_LEN<=32768).
// - Reset mid-fill: immediate abort to IDLE with reset values.
//   - No partial strobe is emitted, and beats arriving after reset are dropped.
// CONFIGURATION
// - FILL_CHECKSUM_EN defined: adds output csum[7:0] (reset 0).
//   - Cleared in GRANT; XOR-accumulates every written byte.
//   - Value is final in DONE and held until the next GRANT.
// - Undefined: no csum port and no accumulator logic; all other behaviour is identical.
// TESTING
// - length=0, start_addr=0x10 -> granted pulse, busy for 2 cycles, no rd_req, no sd_R_nW=0.
// - start_addr=0, length=4, rd_ack immediate, data A0..A3 -> one burst with rd_len=4.
//   - DM writes A0..A3 at addresses 0..3; busy drops after DONE.
// - start_addr=0x1FE, length=6, ROW_LEN=512 -> bursts (0x1FE,2) then (0x200,4).
//   - DM addresses 0..5 are contiguous.
// - rd_ack delayed 5 cycles -> rd_req, rd_addr and rd_len stay stable for all 5 cycles.
//   - A stray rd_valid during ISSUE causes no write.
// - length=DM_DEPTH+1 -> err=1, exactly 65536 writes, sd_addr ends at 0xFFFF; err clears on the next grant.
// - rst asserted after 3 of 8 beats -> all outputs at reset values at once, remaining beats ignored.
//   - A new request is then serviced normally; with FILL_CHECKSUM_EN, csum equals the XOR of the bytes.

Source files
------------

// File: rtl/sdram_fill_resp.sv
// sdram_fill_resp: splits a data-memory block fill into row-bounded SDRAM read bursts and writes each returned byte into DM.
// Optional feature macro FILL_CHECKSUM_EN adds csum, the XOR of every byte written during the current fill.
module sdram_fill_resp #(
  parameter int ROW_LEN  = 512,
  parameter int DM_DEPTH = 65536
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        request,
  input  logic [24:0] start_addr,
  input  logic [24:0] length,
  output logic        granted,
  output logic        busy,
  output logic [15:0] row_length,
  output logic [7:0]  sd_data,
  output logic [15:0] sd_addr,
  output logic        sd_R_nW,
  output logic        err,
  output logic        rd_req,
  output logic [24:0] rd_addr,
  output logic [15:0] rd_len,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data
`ifdef FILL_CHECKSUM_EN
  ,
  output logic [7:0]  csum
`endif
);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, STREAM, DONE} state_t;

  localparam logic [24:0] DEPTH    = 25'(DM_DEPTH);
  localparam logic [24:0] ROW_MASK = 25'(ROW_LEN - 1);
  localparam logic [16:0] ROW_SIZE = 17'(ROW_LEN);

  state_t      state;
  logic [24:0] addr;
  logic [24:0] rem;
  logic [15:0] ptr;
  logic [15:0] beats;

  assign row_length = 16'(ROW_LEN);

  // A burst never crosses an SDRAM row; room is at most ROW_LEN so 17 bits suffice.
  function automatic logic [15:0] burst_len(input logic [24:0] a, input logic [24:0] r);
    logic [16:0] room;
    room = ROW_SIZE - 17'(a & ROW_MASK);
    if (r < {8'd0, room}) return r[15:0];
    return room[15:0];
  endfunction

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      granted <= 1'b0;
      busy    <= 1'b0;
      sd_R_nW <= 1'b1;
      sd_data <= 8'd0;
      sd_addr <= 16'd0;
      rd_req  <= 1'b0;
      rd_addr <= 25'd0;
      rd_len  <= 16'd0;
      err     <= 1'b0;
      addr    <= 25'd0;
      rem     <= 25'd0;
      ptr     <= 16'd0;
      beats   <= 16'd0;
    end else begin
      granted <= 1'b0;
      sd_R_nW <= 1'b1;
      case (state)
        IDLE: begin
          if (request) begin
            addr    <= start_addr;
            rem     <= (length > DEPTH) ? DEPTH : length;
            err     <= (length > DEPTH);
            granted <= 1'b1;
            busy    <= 1'b1;
            ptr     <= 16'd0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (rem == 25'd0) begin
            state <= DONE;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= addr;
            rd_len  <= burst_len(addr, rem);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            beats  <= rd_len;
            state  <= STREAM;
          end
        end
        // The next burst is set up from the post-increment address and count so it is ready the cycle ISSUE starts.
        STREAM: begin
          if (rd_valid) begin
            sd_R_nW <= 1'b0;
            sd_data <= rd_data;
            sd_addr <= ptr;
            ptr     <= ptr + 16'd1;
            addr    <= addr + 25'd1;
            rem     <= rem - 25'd1;
            beats   <= beats - 16'd1;
            if (beats == 16'd1) begin
              if (rem != 25'd1) begin
                rd_req  <= 1'b1;
                rd_addr <= addr + 25'd1;
                rd_len  <= burst_len(addr + 25'd1, rem - 25'd1);
                state   <= ISSUE;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILL_CHECKSUM_EN
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      csum <= 8'd0;
    end else if (state == GRANT) begin
      csum <= 8'd0;
    end else if (state == STREAM && rd_valid) begin
      csum <= csum ^ rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_fill_resp.sv
// tb_sdram_fill_resp: randomized fills against a queue-based model of burst splitting and DM writes.
// A behavioural SDRAM responder answers bursts; a monitor scores every DM write strobe.
module tb_sdram_fill_resp;

  localparam int ROW_LEN  = 512;
  localparam int DM_DEPTH = 65536;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic        request;
  logic [24:0] start_addr;
  logic [24:0] length;
  logic        granted;
  logic        busy;
  logic [15:0] row_length;
  logic [7:0]  sd_data;
  logic [15:0] sd_addr;
  logic        sd_R_nW;
  logic        err;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_ack;
  logic        rd_valid;
  logic [7:0]  rd_data;
`ifdef FILL_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  sdram_fill_resp #(.ROW_LEN(ROW_LEN), .DM_DEPTH(DM_DEPTH)) dut (
    .ref_clk(ref_clk), .rst(rst), .request(request), .start_addr(start_addr), .length(length),
    .granted(granted), .busy(busy), .row_length(row_length), .sd_data(sd_data), .sd_addr(sd_addr),
    .sd_R_nW(sd_R_nW), .err(err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef FILL_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [40:0] exp_bursts[$];
  logic [23:0] exp_writes[$];
  int          exp_nwr;
  logic [15:0] exp_last;
  logic [7:0]  exp_csum;
  logic [7:0]  seed;
  int          wr_count, wr_bad, rdreq_cycles;
  int          ack_delay;
  bit          stray_en, gap_en, resp_busy;
  logic [40:0] eb;
  logic [24:0] ba;
  logic [15:0] bl;
  logic [23:0] ew;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [24:0] a);
    return a[7:0] + (a[15:8] * 8'd3) + seed;
  endfunction

  // Reference: walk the fill byte by byte, cutting a burst at every row boundary.
  task automatic build_model(input logic [24:0] sa, input logic [24:0] len);
    logic [24:0] a, rem, room, blen;
    logic [15:0] p;
    exp_bursts.delete();
    exp_writes.delete();
    rem = (len > 25'(DM_DEPTH)) ? 25'(DM_DEPTH) : len;
    exp_nwr = int'(rem);
    a = sa;
    p = 16'd0;
    exp_csum = 8'd0;
    exp_last = 16'd0;
    while (rem != 25'd0) begin
      room = 25'(ROW_LEN) - (a % 25'(ROW_LEN));
      blen = (rem < room) ? rem : room;
      exp_bursts.push_back({a, blen[15:0]});
      for (int i = 0; i < int'(blen); i++) begin
        exp_writes.push_back({p, byte_of(a)});
        exp_csum = exp_csum ^ byte_of(a);
        exp_last = p;
        a = a + 25'd1;
        p = p + 16'd1;
      end
      rem = rem - blen;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_granted"}, granted, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sd_R_nW"}, sd_R_nW, 1);
    checkOutput({tag, "_sd_data"}, sd_data, 0);
    checkOutput({tag, "_sd_addr"}, sd_addr, 0);
    checkOutput({tag, "_rd_req"}, rd_req, 0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 0);
    checkOutput({tag, "_rd_len"}, rd_len, 0);
    checkOutput({tag, "_err"}, err, 0);
`ifdef FILL_CHECKSUM_EN
    checkOutput({tag, "_csum"}, csum, 0);
`endif
  endtask

  // SDRAM side: acknowledge after ack_delay cycles, then stream the burst the model expects.
  always begin
    @(posedge ref_clk);
    #1;
    if (rd_req === 1'b1 && rst === 1'b0) begin
      resp_busy = 1'b1;
      if (exp_bursts.size() == 0) begin
        checkOutput("unexpected_burst", 1, 0);
        ba = rd_addr;
        bl = rd_len;
      end else begin
        eb = exp_bursts.pop_front();
        ba = eb[40:16];
        bl = eb[15:0];
      end
      for (int d = 0; d < ack_delay; d++) begin
        checkOutput("rd_req_hold", rd_req, 1);
        checkOutput("rd_addr_hold", rd_addr, ba);
        checkOutput("rd_len_hold", rd_len, bl);
        if (stray_en && d == 1) begin
          rd_valid = 1'b1;
          rd_data  = 8'h5A;
        end
        @(posedge ref_clk);
        #1;
        rd_valid = 1'b0;
      end
      checkOutput("rd_addr", rd_addr, ba);
      checkOutput("rd_len", rd_len, bl);
      rd_ack = 1'b1;
      @(posedge ref_clk);
      #1;
      rd_ack = 1'b0;
      checkOutput("rd_req_drop", rd_req, 0);
      for (int i = 0; i < int'(bl); i++) begin
        if (gap_en) begin
          while ($urandom_range(0, 3) == 0) begin
            @(posedge ref_clk);
            #1;
          end
        end
        rd_valid = 1'b1;
        rd_data  = byte_of(ba + 25'(i));
        @(posedge ref_clk);
        #1;
        rd_valid = 1'b0;
      end
      resp_busy = 1'b0;
    end
  end

  always @(negedge ref_clk) begin
    if (rd_req === 1'b1) rdreq_cycles++;
    if (sd_R_nW === 1'b0) begin
      wr_count++;
      if (exp_writes.size() == 0) begin
        wr_bad++;
      end else begin
        ew = exp_writes.pop_front();
        if ({sd_addr, sd_data} !== ew) begin
          wr_bad++;
          $display("[TB] write at 0x%0h data 0x%0h, model 0x%0h data 0x%0h", sd_addr, sd_data, ew[23:8], ew[7:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [24:0] sa, input logic [24:0] len, input int delay,
                               input bit stray, input bit gap);
    int   busy_cycles, limit, g;
    logic exp_err;
    build_model(sa, len);
    exp_err = (len > 25'(DM_DEPTH));
    ack_delay = delay;
    stray_en = stray;
    gap_en = gap;
    wr_count = 0;
    wr_bad = 0;
    rdreq_cycles = 0;
    limit = 4 * exp_nwr + 200;
    @(posedge ref_clk);
    #1;
    request = 1'b1;
    start_addr = sa;
    length = len;
    @(posedge ref_clk);
    #1;
    request = 1'b0;
    @(negedge ref_clk);
    checkOutput("granted", granted, 1);
    checkOutput("busy_at_grant", busy, 1);
    checkOutput("err", err, exp_err);
    busy_cycles = 1;
    @(negedge ref_clk);
    checkOutput("granted_pulse", granted, 0);
    while (busy === 1'b1 && busy_cycles < limit) begin
      busy_cycles++;
      @(negedge ref_clk);
    end
    if (busy === 1'b1) begin
      checkOutput("fill_timeout", 1, 0);
      rst = 1'b1;
      @(posedge ref_clk);
      #1;
      rst = 1'b0;
    end
    g = 0;
    while (resp_busy && g < 5000) begin
      @(negedge ref_clk);
      g++;
    end
    checkOutput("responder_idle", resp_busy, 0);
    checkOutput("write_count", wr_count, exp_nwr);
    checkOutput("write_bad", wr_bad, 0);
    checkOutput("bursts_left", exp_bursts.size(), 0);
    checkOutput("err_hold", err, exp_err);
    checkOutput("rd_req_idle", rd_req, 0);
    if (exp_nwr > 0) checkOutput("sd_addr_final", sd_addr, exp_last);
    if (len == 25'd0) begin
      checkOutput("busy_cycles_empty", busy_cycles, 2);
      checkOutput("rd_req_empty", rdreq_cycles, 0);
    end
`ifdef FILL_CHECKSUM_EN
    checkOutput("csum", csum, exp_csum);
`endif
    exp_bursts.delete();
    exp_writes.delete();
  endtask

  task automatic resetMidFill();
    int n, g;
    seed = 8'($urandom);
    build_model(25'h40, 25'd8);
    ack_delay = 0;
    stray_en = 1'b0;
    gap_en = 1'b0;
    wr_count = 0;
    wr_bad = 0;
    @(posedge ref_clk);
    #1;
    request = 1'b1;
    start_addr = 25'h40;
    length = 25'd8;
    @(posedge ref_clk);
    #1;
    request = 1'b0;
    n = 0;
    g = 0;
    while (n < 3 && g < 100) begin
      @(negedge ref_clk);
      g++;
      if (sd_R_nW === 1'b0) n++;
    end
    checkOutput("rst_three_writes", n, 3);
    rst = 1'b1;
    #1;
    checkReset("mid_fill");
    repeat (3) @(posedge ref_clk);
    #1;
    rst = 1'b0;
    g = 0;
    while ((resp_busy || rd_valid) && g < 100) begin
      @(negedge ref_clk);
      g++;
    end
    repeat (2) @(negedge ref_clk);
    checkOutput("rst_write_count", wr_count, 3);
    checkOutput("rst_write_bad", wr_bad, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_req", rd_req, 0);
    exp_bursts.delete();
    exp_writes.delete();
  endtask

  initial begin
    rst = 1'b1;
    request = 1'b0;
    start_addr = 25'd0;
    length = 25'd0;
    rd_ack = 1'b0;
    rd_valid = 1'b0;
    rd_data = 8'd0;
    ack_delay = 0;
    stray_en = 1'b0;
    gap_en = 1'b0;
    resp_busy = 1'b0;
    wr_count = 0;
    wr_bad = 0;
    rdreq_cycles = 0;
    seed = 8'd0;
    repeat (2) @(negedge ref_clk);
    checkReset("por");
    checkOutput("row_length", row_length, ROW_LEN);
    @(posedge ref_clk);
    #1;
    rst = 1'b0;

    seed = 8'h00;
    applyStimulus(25'h10, 25'd0, 0, 1'b0, 1'b0);
    seed = 8'hA0;
    applyStimulus(25'h0, 25'd4, 0, 1'b0, 1'b0);
    seed = 8'($urandom);
    applyStimulus(25'h1FE, 25'd6, 0, 1'b0, 1'b1);
    seed = 8'($urandom);
    applyStimulus(25'($urandom), 25'($urandom_range(1, 40)), 5, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      seed = 8'($urandom);
      applyStimulus(25'($urandom), 25'($urandom_range(1, 600)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b1);
    end
    resetMidFill();
    seed = 8'($urandom);
    applyStimulus(25'($urandom), 25'd20, 2, 1'b0, 1'b1);
    seed = 8'($urandom);
    applyStimulus(25'($urandom), 25'(DM_DEPTH + 1), 0, 1'b0, 1'b0);
    seed = 8'($urandom);
    applyStimulus(25'($urandom), 25'd20, 1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
